bus_arbiter: RTL
================

BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter AD_LEN, default 32: bus address width.
REQ-002 Parameter BUS_WIDTH, default 32: bus data width.
REQ-003 Parameter TIMEOUT, default 255: maximum BUSY cycles without bus_ack_i before error; legal range 1..65535.
REQ-004 clk_i  input  1  single clock; all logic rising-edge.
REQ-005 reset_i  input  1  reset; asynchronous, active-high.
REQ-006 m_req_i  input  2  per-master request; bit 0 = fetch unit, bit 1 = load/store unit.
REQ-007 m_we_i  input  2  per-master write enable.
REQ-008 m_ad_i  input  2*AD_LEN  per-master address; master n at bits [n*AD_LEN +: AD_LEN].
REQ-009 m_wdata_i  input  2*BUS_WIDTH  per-master write data; same packing.
REQ-010 m_ack_o  output  2  per-master completion pulse.
REQ-011 m_err_o  output  2  per-master timeout-error pulse.
REQ-012 m_rdata_o  output  BUS_WIDTH  shared read data, valid when any m_ack_o bit is high.
REQ-013 bus_cyc_o  output  1  bus cycle active.
REQ-014 bus_we_o  output  1  bus write enable.
REQ-015 bus_ad_o  output  AD_LEN  bus address.
REQ-016 bus_data_o  output  BUS_WIDTH  bus write data.
REQ-017 bus_data_i  input  BUS_WIDTH  bus read data.
REQ-018 bus_ack_i  input  1  slave acknowledge; sampled only while bus_cyc_o=1.
REQ-019 bus_owner_o  output  1  index of the master granted the current or last transaction.

Function
REQ-020 FSM states IDLE, BUSY, DONE; all outputs registered.
REQ-021 IDLE: on an edge with any m_req_i bit set, grant one master, latch its we/ad/wdata onto bus_we_o/bus_ad_o/bus_data_o, set bus_cyc_o=1, set bus_owner_o, zero timeout counter, go BUSY.
REQ-022 Arbitration round-robin: a single requester is granted immediately; when both request, the master indicated by priority pointer rr wins; on every grant, rr <= index of the non-granted master.
REQ-023 BUSY: bus_we_o/bus_ad_o/bus_data_o held stable; m_req_i and m_*_i changes ignored until DONE.
REQ-024 BUSY with bus_ack_i=1 at an edge: m_rdata_o <= bus_data_i (reads and writes alike), m_ack_o[owner] <= 1, bus_cyc_o <= 0, go DONE.
REQ-025 BUSY without ack: counter increments; when counter reaches TIMEOUT-1 without ack, m_err_o[owner] <= 1, bus_cyc_o <= 0, m_rdata_o unchanged, go DONE.
REQ-026 Ack on the same edge as timeout: ack wins; no error pulse.
REQ-027 DONE: lasts exactly one cycle; m_ack_o/m_err_o high only during DONE; no arbitration; go IDLE with ack/err cleared.
REQ-028 Requester protocol: hold m_req_i and operands until ack/err; deassert m_req_i on the edge ending the DONE cycle; a request still high in IDLE is a new transaction.
REQ-029 Latency: request sampled at edge N -> bus_cyc_o high from N; ack sampled at edge M (M >= N+1) -> m_ack_o high for the cycle after M; minimum request-to-ack 2 cycles, back-to-back transaction period 3 cycles plus slave wait states.
REQ-030 At most one bit of m_ack_o|m_err_o is high in any cycle; bus_ack_i while bus_cyc_o=0 is ignored.
REQ-031 Counter width ceil(log2(TIMEOUT+1)); counter never wraps.

Reset
REQ-032 reset_i=1 immediately, independent of clk_i: state IDLE, rr=0, counter=0, all outputs 0 (bus_cyc_o, bus_we_o, bus_ad_o, bus_data_o, m_ack_o, m_err_o, m_rdata_o, bus_owner_o).
REQ-033 Reset during BUSY or DONE aborts the transaction; no ack or error is issued after release.
REQ-034 First edge after reset release with both masters requesting grants master 0.

Verification
REQ-035 Single read: m_req_i=01, m_ad_i[0]=0x1000, slave acks 1st BUSY cycle with 0xDEADBEEF -> bus_ad_o=0x1000, m_ack_o=01 one cycle, m_rdata_o=0xDEADBEEF, 2 cycles req-to-ack.
REQ-036 Contention: m_req_i=11 held, slave acks with 0 wait, requesters drop and reassert per REQ-028 -> grant order 0,1,0,1; bus_owner_o toggles; period 3 cycles.
REQ-037 Write: master 1 we=1, ad=0x20, wdata=0x55AA55AA, 3 wait states -> bus_we_o=1, bus_data_o stable 4 cycles, m_ack_o=10 once.
REQ-038 Timeout: TIMEOUT=4, no ack -> m_err_o[owner] pulses after 4 BUSY cycles, m_ack_o stays 0, m_rdata_o unchanged; ack on 4th BUSY cycle instead -> ack, no error.
REQ-039 Reset mid-BUSY: assert reset_i between edges during BUSY -> bus_cyc_o falls without a clock edge; after release no ack/err; m_req_i=11 -> master 0 granted.
REQ-040 Spurious: bus_ack_i=1 in IDLE, m_req_i=00 -> no outputs change.

Source files
------------

// File: rtl/bus_arbiter_if.sv
// Bundle of signals between the two requesting masters, the arbiter and the
// shared bus slave. The arbiter uses the slave modport. The master modport is
// the mirror view, for whatever drives requests and plays the bus slave.
interface bus_arbiter_if #(
  parameter int AD_LEN    = 32,
  parameter int BUS_WIDTH = 32
);
  logic [1:0]             m_req_i;
  logic [1:0]             m_we_i;
  logic [2*AD_LEN-1:0]    m_ad_i;
  logic [2*BUS_WIDTH-1:0] m_wdata_i;
  logic [1:0]             m_ack_o;
  logic [1:0]             m_err_o;
  logic [BUS_WIDTH-1:0]   m_rdata_o;
  logic                   bus_cyc_o;
  logic                   bus_we_o;
  logic [AD_LEN-1:0]      bus_ad_o;
  logic [BUS_WIDTH-1:0]   bus_data_o;
  logic [BUS_WIDTH-1:0]   bus_data_i;
  logic                   bus_ack_i;
  logic                   bus_owner_o;

  modport slave (
    input  m_req_i, m_we_i, m_ad_i, m_wdata_i, bus_data_i, bus_ack_i,
    output m_ack_o, m_err_o, m_rdata_o, bus_cyc_o, bus_we_o, bus_ad_o,
           bus_data_o, bus_owner_o
  );

  modport master (
    output m_req_i, m_we_i, m_ad_i, m_wdata_i, bus_data_i, bus_ack_i,
    input  m_ack_o, m_err_o, m_rdata_o, bus_cyc_o, bus_we_o, bus_ad_o,
           bus_data_o, bus_owner_o
  );
endinterface

// File: rtl/bus_arbiter.sv
// Two-master round-robin bus arbiter with a per-transaction timeout.
//
// state | meaning
// IDLE  | no transaction; arbitrate among requesting masters
// BUSY  | bus cycle active; waiting for slave ack or timeout
// DONE  | one-cycle ack/err pulse to the owning master
module bus_arbiter #(
  parameter int AD_LEN    = 32,
  parameter int BUS_WIDTH = 32,
  parameter int TIMEOUT   = 255
) (
  input  logic           clk_i,
  input  logic           reset_i,
  bus_arbiter_if.slave   bus
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t               state_q, state_d;
  logic                 rr_q, rr_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 cyc_q, cyc_d;
  logic                 we_q, we_d;
  logic [AD_LEN-1:0]    ad_q, ad_d;
  logic [BUS_WIDTH-1:0] wdata_q, wdata_d;
  logic [1:0]           ack_q, ack_d;
  logic [1:0]           err_q, err_d;
  logic [BUS_WIDTH-1:0] rdata_q, rdata_d;
  logic                 owner_q, owner_d;
  logic                 grant;

  // State and all registered outputs; reset clears everything immediately
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      rr_q    <= 1'b0;
      cnt_q   <= '0;
      cyc_q   <= 1'b0;
      we_q    <= 1'b0;
      ad_q    <= '0;
      wdata_q <= '0;
      ack_q   <= '0;
      err_q   <= '0;
      rdata_q <= '0;
      owner_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
      cyc_q   <= cyc_d;
      we_q    <= we_d;
      ad_q    <= ad_d;
      wdata_q <= wdata_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      owner_q <= owner_d;
    end
  end

  // Next-state, arbitration and next-output values
  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    cnt_d   = cnt_q;
    cyc_d   = cyc_q;
    we_d    = we_q;
    ad_d    = ad_q;
    wdata_d = wdata_q;
    ack_d   = '0;
    err_d   = '0;
    rdata_d = rdata_q;
    owner_d = owner_q;
    grant   = 1'b0;
    case (state_q)
      IDLE: begin
        if (|bus.m_req_i) begin
          // A lone requester wins outright; on contention the pointer decides
          grant   = (bus.m_req_i == 2'b11) ? rr_q : bus.m_req_i[1];
          rr_d    = ~grant;
          owner_d = grant;
          cyc_d   = 1'b1;
          cnt_d   = '0;
          we_d    = bus.m_we_i[grant];
          ad_d    = grant ? bus.m_ad_i[2*AD_LEN-1:AD_LEN] : bus.m_ad_i[AD_LEN-1:0];
          wdata_d = grant ? bus.m_wdata_i[2*BUS_WIDTH-1:BUS_WIDTH]
                          : bus.m_wdata_i[BUS_WIDTH-1:0];
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (bus.bus_ack_i) begin
          // Ack takes precedence even on the terminal-count edge
          rdata_d        = bus.bus_data_i;
          ack_d[owner_q] = 1'b1;
          cyc_d          = 1'b0;
          state_d        = DONE;
        end else if (cnt_q == CNT_LAST) begin
          err_d[owner_q] = 1'b1;
          cyc_d          = 1'b0;
          state_d        = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.m_ack_o     = ack_q;
  assign bus.m_err_o     = err_q;
  assign bus.m_rdata_o   = rdata_q;
  assign bus.bus_cyc_o   = cyc_q;
  assign bus.bus_we_o    = we_q;
  assign bus.bus_ad_o    = ad_q;
  assign bus.bus_data_o  = wdata_q;
  assign bus.bus_owner_o = owner_q;

endmodule
